// File: rtl/draw_pkg.sv
// Shared types and screen constants for the shape-drawing job path.
//
// Contents:
//   job_t       - one queued draw job: colour, centre (cx, cy) and radius (26 bits)
//   seq_state_t - state encoding of the job sequencer FSM
//   SCREEN_W/H  - visible screen size; pixels at or beyond these are clipped
package draw_pkg;

    localparam logic [7:0] SCREEN_W = 8'd160;
    localparam logic [6:0] SCREEN_H = 7'd120;

    typedef struct packed {
        logic [2:0] colour;
        logic [7:0] cx;
        logic [6:0] cy;
        logic [7:0] radius;
    } job_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        START   = 2'd2,
        RELEASE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/job_fifo.sv
// Synchronous FIFO of draw jobs with a registered occupancy count.
//
// Ports:
//   clk, rst    - system clock, synchronous active-high reset (flushes the FIFO)
//   push        - write push_data this cycle (ignored when full)
//   push_data   - job to enqueue
//   pop         - drop the head entry this cycle (ignored when empty)
//   head        - oldest entry, visible combinationally
//   full, empty - decoded from the registered count
module job_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  job_t push_data,
    input  logic pop,
    output job_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    job_t          mem_q [DEPTH];
    job_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/shape_job_sequencer.sv
// Queues shape-draw jobs and runs them one at a time through a shared shape
// engine, clipping the engine's pixels to the screen before the VGA adapter.
//
// Ports:
//   clk, rst                     - system clock, synchronous active-high reset
//   job_valid/job_ready          - job offer handshake; accepted on valid && ready
//   job_colour/cx/cy/radius      - job parameters
//   eng_start                    - level start to the engine (high only in START)
//   eng_colour/cx/cy/radius      - latched job parameters, stable while eng_start=1
//   eng_done                     - engine done, held until eng_start drops
//   eng_x/eng_y/eng_colour_o     - engine pixel
//   eng_plot                     - engine pixel strobe
//   vga_x/vga_y/vga_colour       - registered pixel to the adapter
//   vga_plot                     - registered, clipped plot strobe
//   busy                         - jobs pending or a job in flight
//   jobs_done                    - completed job count, wraps at 16 bits
module shape_job_sequencer
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [2:0]  job_colour,
    input  logic [7:0]  job_cx,
    input  logic [6:0]  job_cy,
    input  logic [7:0]  job_radius,
    output logic        eng_start,
    output logic [2:0]  eng_colour,
    output logic [7:0]  eng_cx,
    output logic [6:0]  eng_cy,
    output logic [7:0]  eng_radius,
    input  logic        eng_done,
    input  logic [7:0]  eng_x,
    input  logic [6:0]  eng_y,
    input  logic [2:0]  eng_colour_o,
    input  logic        eng_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic [15:0] jobs_done
);

    seq_state_t  state_q, state_d;
    job_t        eng_job_q, eng_job_d;
    logic [15:0] jobs_done_q, jobs_done_d;
    logic        vga_plot_q, vga_plot_d;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d;

    job_t job_in;
    job_t fifo_head;
    logic fifo_full, fifo_empty;
    logic push, pop;

    assign job_in    = '{colour: job_colour, cx: job_cx, cy: job_cy, radius: job_radius};
    assign job_ready = !fifo_full;
    assign push      = job_valid && job_ready;

    // The running job stays at the FIFO head until RELEASE completes, so the
    // FIFO count includes it and job_ready reflects that slot as occupied.
    job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (job_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A done already high on entry to START is treated like a fresh one;
    // RELEASE still waits for it to fall, so each job is counted exactly once.
    always_comb begin
        state_d     = state_q;
        eng_job_d   = eng_job_q;
        jobs_done_d = jobs_done_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                eng_job_d = fifo_head;
                state_d   = START;
            end
            START: begin
                if (eng_done) state_d = RELEASE;
            end
            RELEASE: begin
                if (!eng_done) begin
                    pop         = 1'b1;
                    jobs_done_d = jobs_done_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixels are forwarded only while the engine is actually drawing; anything
    // off-screen or emitted after done is dropped rather than wrapped.
    always_comb begin
        vga_plot_d   = eng_plot && (eng_x < SCREEN_W) && (eng_y < SCREEN_H)
                       && (state_q == START);
        vga_x_d      = eng_x;
        vga_y_d      = eng_y;
        vga_colour_d = eng_colour_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            eng_job_q    <= '0;
            jobs_done_q  <= '0;
            vga_plot_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            eng_job_q    <= eng_job_d;
            jobs_done_q  <= jobs_done_d;
            vga_plot_q   <= vga_plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign eng_start  = (state_q == START);
    assign eng_colour = eng_job_q.colour;
    assign eng_cx     = eng_job_q.cx;
    assign eng_cy     = eng_job_q.cy;
    assign eng_radius = eng_job_q.radius;
    assign vga_plot   = vga_plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_shape_job_sequencer.sv
// Self-checking bench for shape_job_sequencer: a behavioural engine drives the
// done handshake, a queue/count model predicts the outputs every cycle, and
// directed sequences pin the model with hand-computed values.
module tb_shape_job_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [2:0]  job_colour = '0;
    logic [7:0]  job_cx = '0;
    logic [6:0]  job_cy = '0;
    logic [7:0]  job_radius = '0;
    logic        eng_start;
    logic [2:0]  eng_colour;
    logic [7:0]  eng_cx;
    logic [6:0]  eng_cy;
    logic [7:0]  eng_radius;
    logic        eng_done;
    logic [7:0]  eng_x = '0;
    logic [6:0]  eng_y = '0;
    logic [2:0]  eng_colour_o = '0;
    logic        eng_plot = 1'b0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic [15:0] jobs_done;

    int n_compared   = 0;
    int n_mismatched = 0;

    shape_job_sequencer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_colour   (job_colour),
        .job_cx       (job_cx),
        .job_cy       (job_cy),
        .job_radius   (job_radius),
        .eng_start    (eng_start),
        .eng_colour   (eng_colour),
        .eng_cx       (eng_cx),
        .eng_cy       (eng_cy),
        .eng_radius   (eng_radius),
        .eng_done     (eng_done),
        .eng_x        (eng_x),
        .eng_y        (eng_y),
        .eng_colour_o (eng_colour_o),
        .eng_plot     (eng_plot),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .busy         (busy),
        .jobs_done    (jobs_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural engine: auto mode raises done eng_delay cycles after start and
    // drops it once start falls; manual mode lets the directed tests own done.
    bit   eng_manual = 1'b0;
    logic man_done   = 1'b0;
    logic auto_done  = 1'b0;
    int   eng_delay  = 500;
    int   eng_cnt    = 0;

    assign eng_done = eng_manual ? man_done : auto_done;

    always @(negedge clk) begin
        if (eng_start) begin
            if (!auto_done) begin
                eng_cnt++;
                if (eng_cnt >= eng_delay) begin
                    auto_done = 1'b1;
                    eng_cnt   = 0;
                end
            end
        end else begin
            eng_cnt   = 0;
            auto_done = 1'b0;
        end
    end

    // Reference model: FIFO occupancy, expected completions and the job order,
    // derived from the handshake rules rather than any internal state.
    typedef struct {
        logic [2:0] c;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] r;
    } job_s;

    job_s        job_q[$];
    job_s        cur_job;
    bit          have_cur    = 1'b0;
    int          occ         = 0;
    logic [15:0] exp_done    = '0;
    bit          awaiting    = 1'b0;
    bit          model_valid = 1'b0;
    bit          start_n     = 1'b0;
    logic        exp_vplot   = 1'b0;
    logic [7:0]  exp_vx      = '0;
    logic [6:0]  exp_vy      = '0;
    logic [2:0]  exp_vc      = '0;
    int          started     = 0;
    int          plot_count  = 0;

    always @(posedge clk) begin
        bit pop_now;
        pop_now = 1'b0;
        if (rst) begin
            occ       = 0;
            exp_done  = '0;
            awaiting  = 1'b0;
            have_cur  = 1'b0;
            exp_vplot = 1'b0;
            exp_vx    = '0;
            exp_vy    = '0;
            exp_vc    = '0;
            job_q.delete();
            model_valid = 1'b1;
        end else begin
            exp_vplot = eng_plot && (eng_x < 8'd160) && (eng_y < 7'd120) && start_n;
            exp_vx    = eng_x;
            exp_vy    = eng_y;
            exp_vc    = eng_colour_o;
            if (start_n && eng_done) begin
                awaiting = 1'b1;
            end else if (awaiting && !start_n && !eng_done) begin
                pop_now  = 1'b1;
                awaiting = 1'b0;
            end
            if (job_valid && occ < DEPTH) begin
                occ++;
                job_q.push_back('{job_colour, job_cx, job_cy, job_radius});
            end
            if (pop_now) begin
                occ--;
                exp_done = exp_done + 16'd1;
            end
        end
    end

    // Compare process: outputs only change at posedge, so negedge is stable.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("job_ready", 32'(job_ready), 32'(occ < DEPTH));
            checkOutput("busy", 32'(busy), 32'(occ != 0));
            checkOutput("jobs_done", 32'(jobs_done), 32'(exp_done));
            checkOutput("vga_plot", 32'(vga_plot), 32'(exp_vplot));
            checkOutput("vga_x", 32'(vga_x), 32'(exp_vx));
            checkOutput("vga_y", 32'(vga_y), 32'(exp_vy));
            checkOutput("vga_colour", 32'(vga_colour), 32'(exp_vc));
            if (eng_start && !start_n) begin
                checkOutput("start_has_job", 32'(job_q.size() > 0), 32'd1);
                if (job_q.size() > 0) begin
                    cur_job  = job_q.pop_front();
                    have_cur = 1'b1;
                    started++;
                end
            end
            if (eng_start && have_cur) begin
                checkOutput("eng_colour", 32'(eng_colour), 32'(cur_job.c));
                checkOutput("eng_cx", 32'(eng_cx), 32'(cur_job.x));
                checkOutput("eng_cy", 32'(eng_cy), 32'(cur_job.y));
                checkOutput("eng_radius", 32'(eng_radius), 32'(cur_job.r));
            end
            if (vga_plot) plot_count++;
        end
        start_n = eng_start;
    end

    // Offers one job and returns at the negedge after it has been accepted.
    task automatic applyStimulus(input logic [2:0] c, input logic [7:0] x,
                                 input logic [6:0] y, input logic [7:0] r);
        int waited;
        waited     = 0;
        job_colour = c;
        job_cx     = x;
        job_cy     = y;
        job_radius = r;
        job_valid  = 1'b1;
        while (!job_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!job_ready) checkOutput("push_timeout", 32'(job_ready), 32'd1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic waitStart(input logic level, input int budget, input string name,
                             output int cycles);
        cycles = 0;
        while (eng_start !== level && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (eng_start !== level) checkOutput(name, 32'(eng_start), 32'(level));
    endtask

    task automatic waitIdle(input int budget, input string name);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (busy !== 1'b0) checkOutput(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int plots_before;
        logic [7:0] px [5];
        logic [6:0] py [5];
        logic       pexp [5];

        repeat (2) @(negedge clk);
        checkOutput("reset_job_ready", 32'(job_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_jobs_done", 32'(jobs_done), 32'd0);
        checkOutput("reset_eng_start", 32'(eng_start), 32'd0);
        checkOutput("reset_vga_plot", 32'(vga_plot), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single long job.
        $display("[TB] single job");
        eng_delay = 500;
        applyStimulus(3'b011, 8'd80, 7'd60, 8'd40);
        waitStart(1'b1, 10, "single_start_timeout", k);
        checkOutput("single_start_latency", 32'(k >= 1 && k <= 3), 32'd1);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (eng_done !== 1'b1 && k < 700);
        checkOutput("single_done_seen", 32'(eng_done), 32'd1);
        @(negedge clk);
        checkOutput("single_start_fall", 32'(eng_start), 32'd0);
        waitIdle(20, "single_idle_timeout");
        checkOutput("single_jobs_done", 32'(jobs_done), 32'd1);
        checkOutput("single_busy", 32'(busy), 32'd0);

        // Five back-to-back jobs into a four-deep FIFO.
        $display("[TB] back-to-back jobs");
        eng_delay = 20;
        applyStimulus(3'd1, 8'd10, 7'd11, 8'd5);
        applyStimulus(3'd2, 8'd20, 7'd22, 8'd6);
        applyStimulus(3'd4, 8'd30, 7'd33, 8'd7);
        applyStimulus(3'd7, 8'd40, 7'd44, 8'd8);
        checkOutput("full_after_4", 32'(job_ready), 32'd0);
        applyStimulus(3'd5, 8'd50, 7'd55, 8'd9);
        checkOutput("fifth_after_pop", 32'(jobs_done), 32'd2);
        waitIdle(500, "b2b_idle_timeout");
        checkOutput("b2b_jobs_done", 32'(jobs_done), 32'd6);
        checkOutput("b2b_started", 32'(started), 32'd6);

        // Clipping at the screen edges.
        $display("[TB] clipping");
        eng_manual = 1'b1;
        man_done   = 1'b0;
        px[0] = 8'd159; py[0] = 7'd60;  pexp[0] = 1'b1;
        px[1] = 8'd160; py[1] = 7'd60;  pexp[1] = 1'b0;
        px[2] = 8'd100; py[2] = 7'd119; pexp[2] = 1'b1;
        px[3] = 8'd100; py[3] = 7'd120; pexp[3] = 1'b0;
        // y=200 does not fit the 7-bit port and arrives as 72; x alone clips it.
        px[4] = 8'd200; py[4] = 7'd72;  pexp[4] = 1'b0;
        plots_before = plot_count;
        applyStimulus(3'd6, 8'd100, 7'd50, 8'd10);
        waitStart(1'b1, 10, "clip_start_timeout", k);
        for (int i = 0; i < 5; i++) begin
            eng_x        = px[i];
            eng_y        = py[i];
            eng_colour_o = 3'(i + 1);
            eng_plot     = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("clip_plot_%0d", i), 32'(vga_plot), 32'(pexp[i]));
            checkOutput($sformatf("clip_x_%0d", i), 32'(vga_x), 32'(px[i]));
        end
        eng_plot = 1'b0;
        man_done = 1'b1;
        waitStart(1'b0, 5, "clip_release_timeout", k);
        man_done = 1'b0;
        waitIdle(10, "clip_idle_timeout");
        checkOutput("clip_plot_count", 32'(plot_count - plots_before), 32'd2);
        checkOutput("clip_jobs_done", 32'(jobs_done), 32'd7);

        // Done already high when the job reaches START.
        $display("[TB] stale done");
        man_done = 1'b1;
        @(negedge clk);
        applyStimulus(3'd2, 8'd70, 7'd30, 8'd3);
        waitStart(1'b1, 10, "stale_start_timeout", k);
        waitStart(1'b0, 3, "stale_release_timeout", k);
        eng_x    = 8'd50;
        eng_y    = 7'd50;
        eng_plot = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stale_no_plot_%0d", i), 32'(vga_plot), 32'd0);
            checkOutput($sformatf("stale_hold_%0d", i), 32'(jobs_done), 32'd7);
        end
        eng_plot = 1'b0;
        man_done = 1'b0;
        waitIdle(10, "stale_idle_timeout");
        checkOutput("stale_jobs_done", 32'(jobs_done), 32'd8);
        eng_manual = 1'b0;

        // Reset while a job is running with two more queued.
        $display("[TB] reset mid-job");
        eng_delay = 500;
        applyStimulus(3'd1, 8'd1, 7'd2, 8'd3);
        applyStimulus(3'd2, 8'd4, 7'd5, 8'd6);
        applyStimulus(3'd3, 8'd7, 7'd8, 8'd9);
        waitStart(1'b1, 10, "rst_start_timeout", k);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_eng_start", 32'(eng_start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_jobs_done", 32'(jobs_done), 32'd0);
        checkOutput("rst_job_ready", 32'(job_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_quiet_%0d", i), 32'(eng_start), 32'd0);
        end

        // Completion counter wrap, preloaded near its limit.
        $display("[TB] counter wrap");
        eng_delay = 1;
        @(posedge clk);
        #1;
        force dut.jobs_done_q = 16'hFFFF;
        exp_done = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.jobs_done_q;
        @(negedge clk);
        checkOutput("wrap_preload", 32'(jobs_done), 32'hFFFF);
        applyStimulus(3'd4, 8'd12, 7'd13, 8'd1);
        waitIdle(20, "wrap_idle_timeout");
        checkOutput("wrap_to_zero", 32'(jobs_done), 32'd0);
        applyStimulus(3'd5, 8'd14, 7'd15, 8'd1);
        waitIdle(20, "wrap_idle2_timeout");
        checkOutput("wrap_then_one", 32'(jobs_done), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
